// File: rtl/alu_sequencer.sv
// Sequences the combinational 6502 alu: a single pass for binary operations and
// three passes (raw sum, low-nibble fix, high-nibble fix) for decimal ADC/SBC.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_c,
  input  logic       req_v,
  input  logic       req_d,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_i_addc,
  output logic       alu_daa,
  output logic       alu_sums,
  output logic       alu_ands,
  output logic       alu_ors,
  output logic       alu_eors,
  output logic       alu_srs,
  input  logic [7:0] alu_out,
  input  logic       alu_acr,
  input  logic       alu_hc,
  input  logic       alu_avr,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_n,
  output logic       rsp_z,
  output logic       rsp_c,
  output logic       rsp_v
);

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ASL = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic [2:0] {IDLE, P1, P2LO, P3HI, RESP} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       daa;
    logic       sums;
    logic       ands;
    logic       ors;
    logic       eors;
    logic       srs;
  } drive_t;

  typedef struct packed {
    logic [7:0] data;
    logic       n;
    logic       z;
    logic       c;
    logic       v;
  } rsp_t;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic       c_q, c_d, v_q, v_d, d_q, d_d;
  logic [3:0] p1hi_q, p1hi_d;
  logic       c1_q, c1_d, v1_q, v1_d;
  logic [3:0] lo_q, lo_d;
  drive_t     drv_q, drv_d;
  rsp_t       rsp_q, rsp_d;

  logic       is_dec, is_addsub, is_nop, uses_c1, load_rsp;
  logic [7:0] res_data;
  logic       res_c, res_v;

  assign is_addsub = (op_q == OP_ADC) || (op_q == OP_SBC);
  assign is_dec    = is_addsub && d_q;
  assign is_nop    = (op_q > OP_CMP);
  assign uses_c1   = op_q inside {OP_ADC, OP_SBC, OP_CMP, OP_LSR, OP_ROR, OP_ASL, OP_ROL};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      d_q     <= 1'b0;
      p1hi_q  <= '0;
      c1_q    <= 1'b0;
      v1_q    <= 1'b0;
      lo_q    <= '0;
      drv_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      c_q     <= c_d;
      v_q     <= v_d;
      d_q     <= d_d;
      p1hi_q  <= p1hi_d;
      c1_q    <= c1_d;
      v1_q    <= v1_d;
      lo_q    <= lo_d;
      drv_q   <= drv_d;
      rsp_q   <= rsp_d;
    end
  end

  // The ALU drive for the next state is computed here and registered, so the
  // combinational alu always sees a clean, request-independent drive.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    c_d      = c_q;
    v_d      = v_q;
    d_d      = d_q;
    p1hi_d   = p1hi_q;
    c1_d     = c1_q;
    v1_d     = v1_q;
    lo_d     = lo_q;
    drv_d    = '0;
    rsp_d    = rsp_q;
    load_rsp = 1'b0;
    res_data = 8'h00;
    res_c    = 1'b0;
    res_v    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = P1;
          op_d    = req_op;
          a_d     = req_a;
          c_d     = req_c;
          v_d     = req_v;
          d_d     = req_d;
          drv_d.a = req_a;
          drv_d.b = req_b;
          case (req_op)
            OP_ADC: begin drv_d.sums = 1'b1; drv_d.cin = req_c; drv_d.daa = req_d; end
            OP_SBC: begin drv_d.sums = 1'b1; drv_d.b = ~req_b; drv_d.cin = req_c; end
            OP_AND: drv_d.ands = 1'b1;
            OP_ORA: drv_d.ors = 1'b1;
            OP_EOR: drv_d.eors = 1'b1;
            OP_LSR: begin drv_d.srs = 1'b1; drv_d.b = 8'h00; end
            OP_ROR: begin drv_d.srs = 1'b1; drv_d.b = 8'h00; drv_d.cin = req_c; end
            OP_ASL: begin drv_d.sums = 1'b1; drv_d.b = req_a; end
            OP_ROL: begin drv_d.sums = 1'b1; drv_d.b = req_a; drv_d.cin = req_c; end
            OP_INC: begin drv_d.sums = 1'b1; drv_d.b = 8'h00; drv_d.cin = 1'b1; end
            OP_DEC: begin drv_d.sums = 1'b1; drv_d.b = 8'hFF; end
            OP_CMP: begin drv_d.sums = 1'b1; drv_d.b = ~req_b; drv_d.cin = 1'b1; end
            default: drv_d = '0;
          endcase
        end
      end
      P1: begin
        p1hi_d = alu_out[7:4];
        c1_d   = alu_acr;
        v1_d   = alu_avr;
        if (is_dec) begin
          state_d    = P2LO;
          drv_d.sums = 1'b1;
          drv_d.a    = {4'h0, alu_out[3:0]};
          if (op_q == OP_ADC) drv_d.b = alu_hc ? 8'h06 : 8'h00;
          else                drv_d.b = alu_hc ? 8'h00 : 8'h0A;
        end else begin
          state_d  = RESP;
          load_rsp = 1'b1;
          res_data = is_nop ? a_q : alu_out;
          res_c    = uses_c1 ? alu_acr : c_q;
          res_v    = is_addsub ? alu_avr : v_q;
        end
      end
      P2LO: begin
        state_d    = P3HI;
        lo_d       = alu_out[3:0];
        drv_d.sums = 1'b1;
        drv_d.a    = {p1hi_q, 4'h0};
        if (op_q == OP_ADC) drv_d.b = c1_q ? 8'h60 : 8'h00;
        else                drv_d.b = c1_q ? 8'h00 : 8'hA0;
      end
      P3HI: begin
        state_d  = RESP;
        load_rsp = 1'b1;
        res_data = {alu_out[7:4], lo_q};
        res_c    = c1_q;
        res_v    = v1_q;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_rsp) begin
      rsp_d.data = res_data;
      rsp_d.n    = res_data[7];
      rsp_d.z    = (res_data == 8'h00);
      rsp_d.c    = res_c;
      rsp_d.v    = res_v;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = drv_q.a;
  assign alu_b      = drv_q.b;
  assign alu_i_addc = drv_q.cin;
  assign alu_daa    = drv_q.daa;
  assign alu_sums   = drv_q.sums;
  assign alu_ands   = drv_q.ands;
  assign alu_ors    = drv_q.ors;
  assign alu_eors   = drv_q.eors;
  assign alu_srs    = drv_q.srs;
  assign rsp_data   = rsp_q.data;
  assign rsp_n      = rsp_q.n;
  assign rsp_z      = rsp_q.z;
  assign rsp_c      = rsp_q.c;
  assign rsp_v      = rsp_q.v;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural 6502 alu closes the loop, directed vectors,
// multi-cycle corner sequences and random ops checked against a flag-level model.
module tb_alu_sequencer;

  logic       clk, rst_n;
  logic       req_valid, req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a, req_b;
  logic       req_c, req_v, req_d;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs;
  logic       alu_acr, alu_hc, alu_avr;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_n, rsp_z, rsp_c, rsp_v;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       n;
    logic       z;
    logic       c;
    logic       v;
  } rsp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       v;
    logic       d;
    logic [7:0] expData;
    logic       expN;
    logic       expZ;
    logic       expC;
    logic       expV;
    int         expLat;
  } vec_t;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_v(req_v), .req_d(req_d),
    .alu_a(alu_a), .alu_b(alu_b), .alu_i_addc(alu_i_addc), .alu_daa(alu_daa),
    .alu_sums(alu_sums), .alu_ands(alu_ands), .alu_ors(alu_ors), .alu_eors(alu_eors),
    .alu_srs(alu_srs), .alu_out(alu_out), .alu_acr(alu_acr), .alu_hc(alu_hc),
    .alu_avr(alu_avr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 6502 alu: decimal mode adjusts nibble carries at >9.
  logic [4:0] aluLo, aluHi;
  logic [8:0] aluBin;
  always_comb begin
    alu_out = 8'h00; alu_acr = 1'b0; alu_hc = 1'b0; alu_avr = 1'b0;
    aluLo = 5'd0; aluHi = 5'd0; aluBin = 9'd0;
    if (alu_sums) begin
      aluLo   = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, alu_i_addc};
      alu_hc  = alu_daa ? (aluLo > 5'd9) : aluLo[4];
      aluHi   = {1'b0, alu_a[7:4]} + {1'b0, alu_b[7:4]} + {4'b0, alu_hc};
      alu_acr = alu_daa ? (aluHi > 5'd9) : aluHi[4];
      alu_out = {aluHi[3:0], aluLo[3:0]};
      aluBin  = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_i_addc};
      alu_avr = (alu_a[7] == alu_b[7]) && (aluBin[7] != alu_a[7]);
    end else if (alu_ands) alu_out = alu_a & alu_b;
    else if (alu_ors)      alu_out = alu_a | alu_b;
    else if (alu_eors)     alu_out = alu_a ^ alu_b;
    else if (alu_srs) begin
      alu_out = {alu_i_addc, alu_a[7:1]};
      alu_acr = alu_a[0];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int bcdVal(input logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [7:0] toBcd(input int s);
    logic [3:0] tens, units;
    tens  = 4'(s / 10);
    units = 4'(s % 10);
    return {tens, units};
  endfunction

  function automatic logic ovf(input int s);
    return (s > 127) || (s < -128);
  endfunction

  // Flag-level model of each instruction; decimal results use true BCD arithmetic.
  function automatic rsp_t refModel(input logic [3:0] op, input logic [7:0] a, b, input logic c, v, d);
    rsp_t r;
    int s;
    r.data = a; r.c = c; r.v = v;
    case (op)
      4'd0: begin
        r.v = ovf(int'($signed(a)) + int'($signed(b)) + int'(c));
        if (d) begin
          s = bcdVal(a) + bcdVal(b) + int'(c);
          r.c = (s >= 100); r.data = toBcd(s % 100);
        end else begin
          s = int'(a) + int'(b) + int'(c);
          r.c = (s > 255); r.data = 8'(s);
        end
      end
      4'd1: begin
        r.v = ovf(int'($signed(a)) - int'($signed(b)) - (1 - int'(c)));
        if (d) begin
          s = bcdVal(a) - bcdVal(b) - (1 - int'(c));
          r.c = (s >= 0); r.data = toBcd((s + 100) % 100);
        end else begin
          s = int'(a) - int'(b) - (1 - int'(c));
          r.c = (s >= 0); r.data = 8'(s);
        end
      end
      4'd2:  r.data = a & b;
      4'd3:  r.data = a | b;
      4'd4:  r.data = a ^ b;
      4'd5:  begin r.data = a >> 1; r.c = a[0]; end
      4'd6:  begin r.data = {c, a[7:1]}; r.c = a[0]; end
      4'd7:  begin r.data = a << 1; r.c = a[7]; end
      4'd8:  begin r.data = {a[6:0], c}; r.c = a[7]; end
      4'd9:  r.data = a + 8'd1;
      4'd10: r.data = a - 8'd1;
      4'd11: begin s = int'(a) - int'(b); r.c = (s >= 0); r.data = 8'(s); end
      default: r.data = a;
    endcase
    r.n = r.data[7];
    r.z = (r.data == 8'h00);
    return r;
  endfunction

  // Issues one request, scrambles req_* after the accept edge, waits for the
  // response, optionally stalls it, and completes the handshake.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, b, input logic c, v, d,
                               input int hold, output rsp_t got, output int lat);
    rsp_t snap;
    checkOutput("reqReadyBeforeIssue", req_ready, 1'b1);
    req_op = op; req_a = a; req_b = b; req_c = c; req_v = v; req_d = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    req_c = 1'($urandom); req_v = 1'($urandom); req_d = 1'($urandom);
    rsp_ready = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    snap = {rsp_data, rsp_n, rsp_z, rsp_c, rsp_v};
    got = snap;
    repeat (hold) @(negedge clk);
    if (hold > 0)
      checkOutput("stableUnderStall", {rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_v}, {1'b1, snap});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  vec_t vecs[16];
  rsp_t got, expR;
  int   lat;

  initial begin
    vecs[0]  = '{op:4'd0,  a:8'h50, b:8'h50, c:0, v:0, d:0, expData:8'hA0, expN:1, expZ:0, expC:0, expV:1, expLat:2};
    vecs[1]  = '{op:4'd0,  a:8'h58, b:8'h46, c:1, v:0, d:1, expData:8'h05, expN:0, expZ:0, expC:1, expV:1, expLat:4};
    vecs[2]  = '{op:4'd1,  a:8'h12, b:8'h05, c:1, v:0, d:1, expData:8'h07, expN:0, expZ:0, expC:1, expV:0, expLat:4};
    vecs[3]  = '{op:4'd6,  a:8'h01, b:8'h00, c:1, v:0, d:0, expData:8'h80, expN:1, expZ:0, expC:1, expV:0, expLat:2};
    vecs[4]  = '{op:4'd2,  a:8'hF0, b:8'h0F, c:1, v:1, d:0, expData:8'h00, expN:0, expZ:1, expC:1, expV:1, expLat:2};
    vecs[5]  = '{op:4'd11, a:8'h10, b:8'h20, c:1, v:0, d:0, expData:8'hF0, expN:1, expZ:0, expC:0, expV:0, expLat:2};
    vecs[6]  = '{op:4'd12, a:8'h7E, b:8'h11, c:1, v:1, d:1, expData:8'h7E, expN:0, expZ:0, expC:1, expV:1, expLat:2};
    vecs[7]  = '{op:4'd7,  a:8'h81, b:8'h00, c:0, v:0, d:0, expData:8'h02, expN:0, expZ:0, expC:1, expV:0, expLat:2};
    vecs[8]  = '{op:4'd10, a:8'h00, b:8'h00, c:0, v:1, d:0, expData:8'hFF, expN:1, expZ:0, expC:0, expV:1, expLat:2};
    vecs[9]  = '{op:4'd1,  a:8'h80, b:8'h01, c:1, v:0, d:0, expData:8'h7F, expN:0, expZ:0, expC:1, expV:1, expLat:2};
    vecs[10] = '{op:4'd0,  a:8'h99, b:8'h01, c:0, v:1, d:1, expData:8'h00, expN:0, expZ:1, expC:1, expV:0, expLat:4};
    vecs[11] = '{op:4'd5,  a:8'h03, b:8'hFF, c:0, v:0, d:0, expData:8'h01, expN:0, expZ:0, expC:1, expV:0, expLat:2};
    vecs[12] = '{op:4'd9,  a:8'hFF, b:8'h00, c:0, v:0, d:0, expData:8'h00, expN:0, expZ:1, expC:0, expV:0, expLat:2};
    vecs[13] = '{op:4'd8,  a:8'h80, b:8'h00, c:1, v:0, d:0, expData:8'h01, expN:0, expZ:0, expC:1, expV:0, expLat:2};
    vecs[14] = '{op:4'd4,  a:8'hFF, b:8'h0F, c:0, v:0, d:0, expData:8'hF0, expN:1, expZ:0, expC:0, expV:0, expLat:2};
    vecs[15] = '{op:4'd3,  a:8'h00, b:8'h00, c:0, v:0, d:0, expData:8'h00, expN:0, expZ:1, expC:0, expV:0, expLat:2};

    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 8'h00; req_b = 8'h00;
    req_c = 1'b0; req_v = 1'b0; req_d = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetReqReady", req_ready, 1'b1);
    checkOutput("resetDrive", {alu_a, alu_b, alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs}, 0);
    checkOutput("resetRsp", {rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_v}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].v, vecs[i].d, 0, got, lat);
      checkOutput($sformatf("vec%0d data", i), got.data, vecs[i].expData);
      checkOutput($sformatf("vec%0d nzcv", i), {got.n, got.z, got.c, got.v},
                  {vecs[i].expN, vecs[i].expZ, vecs[i].expC, vecs[i].expV});
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
    end

    // Decimal ADC: watch each of the three passes.
    @(negedge clk);
    req_op = 4'd0; req_a = 8'h58; req_b = 8'h46; req_c = 1'b1; req_v = 1'b0; req_d = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("decAdcP1Out", alu_out, 8'hAF);
    checkOutput("decAdcP1SumsDaa", {alu_sums, alu_daa}, 2'b11);
    @(negedge clk);
    checkOutput("decAdcP2A", alu_a, 8'h0F);
    checkOutput("decAdcP2B", alu_b, 8'h06);
    @(negedge clk);
    checkOutput("decAdcP3A", alu_a, 8'hA0);
    checkOutput("decAdcP3B", alu_b, 8'h60);
    checkOutput("decAdcP3NotValid", rsp_valid, 1'b0);
    @(negedge clk);
    checkOutput("decAdcValid", rsp_valid, 1'b1);
    checkOutput("decAdcDataC", {rsp_data, rsp_c, rsp_z}, {8'h05, 1'b1, 1'b0});
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Decimal SBC: raw difference and low-nibble borrow correction.
    @(negedge clk);
    req_op = 4'd1; req_a = 8'h12; req_b = 8'h05; req_c = 1'b1; req_d = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("decSbcP1Out", {alu_out, alu_hc, alu_acr}, {8'h0D, 1'b0, 1'b1});
    @(negedge clk);
    checkOutput("decSbcP2B", alu_b, 8'h0A);
    repeat (2) @(negedge clk);
    checkOutput("decSbcResult", {rsp_valid, rsp_data, rsp_c}, {1'b1, 8'h07, 1'b1});
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Reset in the middle of P1 drops the operation.
    @(negedge clk);
    req_op = 4'd0; req_a = 8'h11; req_b = 8'h22; req_c = 1'b0; req_d = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midP1Sums", alu_sums, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetReqReady", req_ready, 1'b1);
    checkOutput("midResetDrive", {alu_a, alu_b, alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs}, 0);
    checkOutput("midResetRspValid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("afterResetIdle", {req_ready, rsp_valid}, 2'b10);

    // Backpressure on CMP: response held stable, no new request accepted.
    req_op = 4'd11; req_a = 8'h10; req_b = 8'h20; req_c = 1'b1; req_v = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_a = 8'h33;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    checkOutput("bpLatency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bpHold%0d", k), {rsp_valid, rsp_data, rsp_c, rsp_n, req_ready},
                  {1'b1, 8'hF0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    checkOutput("bpReleaseIdle", {req_ready, rsp_valid}, 2'b10);

    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      logic       c, v, d;
      int         hold, expLat;
      op = 4'($urandom_range(0, 15));
      c = 1'($urandom); v = 1'($urandom); d = 1'($urandom);
      if (op <= 4'd1 && d) begin
        a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        a = 8'($urandom); b = 8'($urandom);
      end
      hold = $urandom_range(0, 3);
      expR = refModel(op, a, b, c, v, d);
      expLat = (op <= 4'd1 && d) ? 4 : 2;
      applyStimulus(op, a, b, c, v, d, hold, got, lat);
      checkOutput($sformatf("rnd%0d op%0d data", n, op), got.data, expR.data);
      checkOutput($sformatf("rnd%0d op%0d nzcv", n, op), {got.n, got.z, got.c, got.v},
                  {expR.n, expR.z, expR.c, expR.v});
      checkOutput($sformatf("rnd%0d op%0d latency", n, op), lat, expLat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
